// File: rtl/param_updown_counter_if.sv
// Bundle for param_updown_counter: control inputs, compare value and status outputs.
// Clock and reset are not part of the bundle; they stay scalar ports on the counter.
//
//   p        Width  parallel load data
//   pe_n     1      parallel load enable, active-low
//   cep      1      count enable, parallel
//   cet      1      count enable, trickle; also gates tc
//   ud       1      direction: 1 = up, 0 = down
//   cmp      Width  compare value for match
//   clr_ovf  1      clear sticky wrap flag, active-high
//   q        Width  counter value (registered)
//   tc       1      terminal count (combinational)
//   match    1      registered compare flag
//   ovf      1      sticky wrap flag (registered)
interface param_updown_counter_if #(
    parameter int unsigned Width = 4
) ();
    logic [Width-1:0] p;
    logic             pe_n;
    logic             cep;
    logic             cet;
    logic             ud;
    logic [Width-1:0] cmp;
    logic             clr_ovf;
    logic [Width-1:0] q;
    logic             tc;
    logic             match;
    logic             ovf;

    // Whoever drives the controls and observes the count.
    modport master (
        output p, pe_n, cep, cet, ud, cmp, clr_ovf,
        input  q, tc, match, ovf
    );

    // The counter itself.
    modport slave (
        input  p, pe_n, cep, cet, ud, cmp, clr_ovf,
        output q, tc, match, ovf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter, modulo MaxCount+1, with saturating parallel
// load, two-input count enable, cascadable terminal count, compare-match and a sticky
// wrap flag.
//
// Ports:
//   clk_i   clock; all state changes on the rising edge
//   rst_ni  synchronous reset, active-low; overrides load, count and clr_ovf
//   bus     param_updown_counter_if.slave (see the interface file for the signal list)
//
// Edge priority: reset, then load (pe_n=0), then count (cep & cet), else hold.
// Cascade: feed tc of a stage into cet of the next; share cep and ud across stages.
module param_updown_counter #(
    parameter int unsigned Width    = 4,
    parameter int unsigned MaxCount = 2 ** Width - 1
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    param_updown_counter_if.slave bus
);

    localparam logic [Width-1:0] MaxVal = Width'(MaxCount);

    logic [Width-1:0] q_q, q_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;

    logic at_top;
    logic at_bottom;
    logic count_en;
    logic wrap;

    always_comb begin
        at_top    = (q_q == MaxVal);
        at_bottom = (q_q == '0);
        count_en  = bus.cep & bus.cet;
        wrap      = 1'b0;
        q_d       = q_q;

        if (!bus.pe_n) begin
            // Out-of-range load data saturates so q never leaves 0..MaxCount.
            q_d = (bus.p > MaxVal) ? MaxVal : bus.p;
        end else if (count_en) begin
            if (bus.ud) begin
                if (at_top) begin
                    q_d  = '0;
                    wrap = 1'b1;
                end else begin
                    q_d = q_q + Width'(1);
                end
            end else begin
                if (at_bottom) begin
                    q_d  = MaxVal;
                    wrap = 1'b1;
                end else begin
                    q_d = q_q - Width'(1);
                end
            end
        end

        // A wrap in the same cycle as a clear leaves the flag set.
        ovf_d = ovf_q;
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end

        // Compared against the pre-update value, so match lags q by one cycle.
        match_d = (q_q == bus.cmp);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q     <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.match = match_q;
    assign bus.ovf   = ovf_q;
    // Independent of cep and pe_n so a cascade can look ahead on the trickle chain.
    assign bus.tc    = bus.cet & (bus.ud ? at_top : at_bottom);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: one decade instance (MaxCount=9) and a two-stage
// cascade of 4-bit binary instances. A behavioural model tracks all three and is compared
// on every falling edge; directed sequences add hand-computed literal checks.
module tb_param_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: decade, 1: cascade low, 2: cascade high (cep/ud/cet come from the low stage).
    logic       rst_v[3];
    logic [3:0] p_v[3];
    logic       pe_v[3];
    logic       cep_v[3];
    logic       cet_v[3];
    logic       ud_v[3];
    logic [3:0] cmp_v[3];
    logic       clr_v[3];

    logic [3:0] dq[3];
    logic       dtc[3];
    logic       dmatch[3];
    logic       dovf[3];

    param_updown_counter_if #(.Width(4)) bus_dec ();
    param_updown_counter_if #(.Width(4)) bus_lo ();
    param_updown_counter_if #(.Width(4)) bus_hi ();

    param_updown_counter #(.Width(4), .MaxCount(9)) u_dec (
        .clk_i  (clk),
        .rst_ni (rst_v[0]),
        .bus    (bus_dec)
    );

    param_updown_counter #(.Width(4), .MaxCount(15)) u_lo (
        .clk_i  (clk),
        .rst_ni (rst_v[1]),
        .bus    (bus_lo)
    );

    param_updown_counter #(.Width(4), .MaxCount(15)) u_hi (
        .clk_i  (clk),
        .rst_ni (rst_v[2]),
        .bus    (bus_hi)
    );

    assign bus_dec.p       = p_v[0];
    assign bus_dec.pe_n    = pe_v[0];
    assign bus_dec.cep     = cep_v[0];
    assign bus_dec.cet     = cet_v[0];
    assign bus_dec.ud      = ud_v[0];
    assign bus_dec.cmp     = cmp_v[0];
    assign bus_dec.clr_ovf = clr_v[0];

    assign bus_lo.p       = p_v[1];
    assign bus_lo.pe_n    = pe_v[1];
    assign bus_lo.cep     = cep_v[1];
    assign bus_lo.cet     = cet_v[1];
    assign bus_lo.ud      = ud_v[1];
    assign bus_lo.cmp     = cmp_v[1];
    assign bus_lo.clr_ovf = clr_v[1];

    assign bus_hi.p       = p_v[2];
    assign bus_hi.pe_n    = pe_v[2];
    assign bus_hi.cep     = cep_v[1];
    assign bus_hi.cet     = bus_lo.tc;
    assign bus_hi.ud      = ud_v[1];
    assign bus_hi.cmp     = cmp_v[2];
    assign bus_hi.clr_ovf = clr_v[2];

    assign dq[0] = bus_dec.q;  assign dtc[0] = bus_dec.tc;
    assign dq[1] = bus_lo.q;   assign dtc[1] = bus_lo.tc;
    assign dq[2] = bus_hi.q;   assign dtc[2] = bus_hi.tc;
    assign dmatch[0] = bus_dec.match;  assign dovf[0] = bus_dec.ovf;
    assign dmatch[1] = bus_lo.match;   assign dovf[1] = bus_lo.ovf;
    assign dmatch[2] = bus_hi.match;   assign dovf[2] = bus_hi.ovf;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int mq[3];
    int mmatch[3];
    int movf[3];
    int mmax[3] = '{9, 15, 15};

    function automatic bit raw_tc(input int i, input bit c);
        return c && ((ud_v[(i == 2) ? 1 : i]) ? (mq[i] == mmax[i]) : (mq[i] == 0));
    endfunction

    function automatic bit eff_cet(input int i);
        return (i == 2) ? raw_tc(1, cet_v[1]) : cet_v[i];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int src  = (i == 2) ? 1 : i;
            automatic int nq   = mq[i];
            automatic int novf = movf[i];
            automatic bit wrp  = 1'b0;
            if (!rst_v[i]) begin
                nq   = 0;
                novf = 0;
            end else begin
                if (!pe_v[i]) begin
                    nq = (int'(p_v[i]) > mmax[i]) ? mmax[i] : int'(p_v[i]);
                end else if (cep_v[src] && eff_cet(i)) begin
                    if (ud_v[src]) begin
                        wrp = (mq[i] == mmax[i]);
                        nq  = (mq[i] + 1) % (mmax[i] + 1);
                    end else begin
                        wrp = (mq[i] == 0);
                        nq  = (mq[i] + mmax[i]) % (mmax[i] + 1);
                    end
                end
                if (wrp) novf = 1;
                else if (clr_v[i]) novf = 0;
            end
            mq[i]     <= nq;
            movf[i]   <= novf;
            mmatch[i] <= (rst_v[i] && (mq[i] == int'(cmp_v[i]))) ? 1 : 0;
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model q[%0d]", i), 32'(dq[i]), mq[i]);
                check($sformatf("model tc[%0d]", i), 32'(dtc[i]), raw_tc(i, eff_cet(i)) ? 1 : 0);
                check($sformatf("model match[%0d]", i), 32'(dmatch[i]), mmatch[i]);
                check($sformatf("model ovf[%0d]", i), 32'(dovf[i]), movf[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; p_v[i] = '0; pe_v[i] = 1'b1; cep_v[i] = 1'b0;
            cet_v[i] = 1'b0; ud_v[i] = 1'b1; cmp_v[i] = 4'd0; clr_v[i] = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;
        chk_en = 1'b1;

        // Reset state; tc after reset = cet & ~ud.
        for (int i = 0; i < 3; i++) begin
            check("reset q", 32'(dq[i]), 0);
            check("reset ovf", 32'(dovf[i]), 0);
            check("reset match", 32'(dmatch[i]), 0);
        end
        cet_v[0] = 1'b1; ud_v[0] = 1'b0;
        #1;
        check("tc after reset, down", 32'(dtc[0]), 1);
        cet_v[0] = 1'b0; ud_v[0] = 1'b1;

        // Reset beats load and count (binary, MaxCount=15).
        cep_v[1] = 1'b1; cet_v[1] = 1'b1; ud_v[1] = 1'b1;
        repeat (7) tick();
        check("bin count to 7", 32'(dq[1]), 7);
        rst_v[1] = 1'b0; pe_v[1] = 1'b0; p_v[1] = 4'd5;
        tick();
        check("reset over load q", 32'(dq[1]), 0);
        check("reset over load ovf", 32'(dovf[1]), 0);
        check("reset over load match", 32'(dmatch[1]), 0);
        rst_v[1] = 1'b1; pe_v[1] = 1'b1; cep_v[1] = 1'b0;
        repeat (3) tick();
        check("hold with cep=0", 32'(dq[1]), 0);
        cet_v[1] = 1'b0;

        // Decade up-count.
        ud_v[0] = 1'b1; cep_v[0] = 1'b1; cet_v[0] = 1'b1; cmp_v[0] = 4'd15;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("decade up q=%0d", k), 32'(dq[0]), k);
        end
        check("decade tc at 9", 32'(dtc[0]), 1);
        tick();
        check("decade wrap q", 32'(dq[0]), 0);
        check("decade wrap ovf", 32'(dovf[0]), 1);
        repeat (9) tick();
        cet_v[0] = 1'b0;
        #1;
        check("tc gated by cet", 32'(dtc[0]), 0);
        tick();
        check("hold at 9 with cet=0", 32'(dq[0]), 9);

        // Clear ovf, saturating load, down-count through zero.
        cep_v[0] = 1'b0; clr_v[0] = 1'b1;
        tick();
        clr_v[0] = 1'b0;
        check("ovf cleared", 32'(dovf[0]), 0);
        pe_v[0] = 1'b0; p_v[0] = 4'd12;
        tick();
        pe_v[0] = 1'b1;
        check("saturating load", 32'(dq[0]), 9);
        ud_v[0] = 1'b0; cep_v[0] = 1'b1; cet_v[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("decade down step %0d", k), 32'(dq[0]), (k < 10) ? 9 - k : 9);
            if (k == 9) begin
                check("down tc at 0", 32'(dtc[0]), 1);
                check("no ovf before down wrap", 32'(dovf[0]), 0);
            end
            if (k == 10) check("ovf on 0->9", 32'(dovf[0]), 1);
        end

        // Load beats count; wrap beats clear.
        cep_v[0] = 1'b0; clr_v[0] = 1'b1;
        tick();
        clr_v[0] = 1'b0;
        check("ovf cleared again", 32'(dovf[0]), 0);
        ud_v[0] = 1'b1; pe_v[0] = 1'b0; p_v[0] = 4'd3; cep_v[0] = 1'b1;
        tick();
        pe_v[0] = 1'b1;
        check("load over count q", 32'(dq[0]), 3);
        check("load leaves ovf", 32'(dovf[0]), 0);
        repeat (6) tick();
        check("up to 9", 32'(dq[0]), 9);
        clr_v[0] = 1'b1;
        tick();
        check("wrap with clr q", 32'(dq[0]), 0);
        check("wrap wins over clr", 32'(dovf[0]), 1);
        tick();
        clr_v[0] = 1'b0;
        check("clr without wrap q", 32'(dq[0]), 1);
        check("clr without wrap ovf", 32'(dovf[0]), 0);

        // Match lags q by one cycle.
        cmp_v[0] = 4'd5; pe_v[0] = 1'b0; p_v[0] = 4'd3;
        tick();
        pe_v[0] = 1'b1;
        check("match load q", 32'(dq[0]), 3);
        check("match after load", 32'(dmatch[0]), 0);
        tick();
        check("match at q=4", 32'(dmatch[0]), 0);
        tick();
        check("match at q=5", 32'(dmatch[0]), 0);
        tick();
        check("match at q=6", 32'(dmatch[0]), 1);
        tick();
        check("match at q=7", 32'(dmatch[0]), 0);
        cep_v[0] = 1'b0;

        // Cascade up: 0x0E + 2 = 0x10.
        pe_v[1] = 1'b0; pe_v[2] = 1'b0; p_v[1] = 4'd14; p_v[2] = 4'd0;
        cep_v[1] = 1'b0; ud_v[1] = 1'b1; cet_v[1] = 1'b1;
        tick();
        pe_v[1] = 1'b1; pe_v[2] = 1'b1; cep_v[1] = 1'b1;
        tick();
        check("cascade up 1 low", 32'(dq[1]), 15);
        check("cascade up 1 high", 32'(dq[2]), 0);
        tick();
        check("cascade up 2 low", 32'(dq[1]), 0);
        check("cascade up 2 high", 32'(dq[2]), 1);

        // Cascade down: 0x10 - 1 = 0x0F.
        pe_v[1] = 1'b0; pe_v[2] = 1'b0; p_v[1] = 4'd0; p_v[2] = 4'd1; cep_v[1] = 1'b0;
        tick();
        pe_v[1] = 1'b1; pe_v[2] = 1'b1; ud_v[1] = 1'b0; cep_v[1] = 1'b1;
        tick();
        check("cascade down low", 32'(dq[1]), 15);
        check("cascade down high", 32'(dq[2]), 0);
        cep_v[1] = 1'b0;
        repeat (2) tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
